div: RTL and testbench
======================

Name: div

Overview:
Sequential restoring (shift-subtract) divider. It is the inverse companion of the shift-add multiplier in the voice datapath. It is used where a value must be scaled down by a runtime 8-bit divisor, such as envelope rate and filter coefficient normalisation. One quotient bit is resolved per clock, so area stays minimal for the TinyTapeout footprint.

Parameters:
WIDTH_N, 10, dividend and quotient width in bits; also the iteration count.
WIDTH_D, 8, divisor and remainder width in bits.

Ports:
clk_i  input  1  system clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
start_i  input  1  request a division; sampled only while ready_o=1.
num_i  input  WIDTH_N  dividend, unsigned.
den_i  input  WIDTH_D  divisor, unsigned.
ready_o  output  1  high while idle; a start is accepted only when high.
done_o  output  1  one-cycle pulse marking completion and updated results.
quot_o  output  WIDTH_N  quotient, registered.
rem_o  output  WIDTH_D  remainder, registered.
dz_o  output  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: state IDLE, ready_o=1, done_o=0, quot_o=0, rem_o=0, dz_o=0. All internal registers are cleared.
- FSM has two states, IDLE and ITER:
  - IDLE -> ITER when start_i=1.
  - ITER -> IDLE after the step with iteration counter = WIDTH_N-1.
  - ready_o = (state == IDLE).
- Accept: on the rising edge where state=IDLE and start_i=1:
  - latch num_i into the quotient shift register and den_i into the divisor register;
  - clear the partial remainder (WIDTH_D+1 bits);
  - clear the counter;
  - capture dz = (den_i == 0).
- Iteration, one per ITER cycle:
  - r' = {r[WIDTH_D-1:0], q[MSB]};
  - q shifts left by one;
  - if r' >= d then r = r' - d and q[0] = 1, else r = r' and q[0] = 0;
  - counter increments.
- Latency:
  - ready_o is low for exactly WIDTH_N cycles after the accepting edge.
  - On the edge ending the last iteration, the results are copied to quot_o, rem_o and dz_o, and done_o is set.
  - done_o is high for exactly one cycle, the first cycle in which ready_o is high again.
- Output hold: quot_o, rem_o and dz_o change only at completion. They stay stable through a subsequent operation until that operation completes.
- Divide by zero: the operation still takes the full WIDTH_N cycles, so latency is fixed. At completion quot_o is forced to all ones, rem_o=0 and dz_o=1.
- Width rules:
  - All arithmetic is unsigned.
  - The final remainder is always < den, so it fits in WIDTH_D bits.
  - No rounding; the quotient is floor(num/den).
- start_i while busy (ready_o=0): ignored. It is not queued and the operands are not sampled.
- Back-to-back: a start_i in the done_o cycle is accepted, because ready_o=1 in that cycle. The new operation begins while the previous results stay on the outputs.
- Operands: num_i and den_i are sampled only at the accepting edge. Changes during ITER have no effect.
- Reset mid-operation: all state aborts immediately to reset values. No done_o is produced for the aborted operation.

Test Plan:
- After reset: ready_o=1, done_o=0, quot_o=0, rem_o=0, dz_o=0. Start with num=1000, den=7 -> ready_o low for 10 cycles, then done_o pulses once with quot_o=142, rem_o=6, dz_o=0.
- Edge values: 1023/255 -> quot_o=4, rem_o=3. 1023/1 -> quot_o=1023, rem_o=0. 0/13 -> quot_o=0, rem_o=0.
- Divide by zero: num=5, den=0 -> done_o after 10 cycles, quot_o=1023, rem_o=0, dz_o=1. The next operation 9/4 -> quot_o=2, rem_o=1, dz_o=0.
- Start while busy: pulse start_i with 50/5 three cycles into 100/3 -> single done_o, quot_o=33, rem_o=1; the second request is dropped.
- Back-to-back: assert start_i (200/9) in the done_o cycle of 100/3 -> quot_o=33 and rem_o=1 hold for 10 cycles, then update to 22 and 2 with a second done_o pulse.
- Reset mid-operation: assert rst_ni=0 five cycles into 1000/7 -> outputs go to reset values immediately. No done_o follows; the next 64/8 gives quot_o=8, rem_o=0.

Source files
------------

// File: rtl/div.sv
// Sequential restoring divider: floor(num/den) and num%den, one quotient bit per clock.
// Latency: WIDTH_N cycles from the accepting edge; done_o pulses in the first ready cycle.
// Backpressure: a start is accepted only while ready_o=1; starts while busy are dropped.
module div #(
    parameter int WIDTH_N = 10,
    parameter int WIDTH_D = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WIDTH_N-1:0] num_i,
    input  logic [WIDTH_D-1:0] den_i,
    output logic               ready_o,
    output logic               done_o,
    output logic [WIDTH_N-1:0] quot_o,
    output logic [WIDTH_D-1:0] rem_o,
    output logic               dz_o
);

    localparam int CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH_N-1:0]   q_q, q_d;
    logic [WIDTH_D-1:0]   d_q, d_d;
    logic [WIDTH_D:0]     r_q, r_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 dz_q, dz_d;
    logic [WIDTH_N-1:0]   quot_q, quot_d;
    logic [WIDTH_D-1:0]   rem_q, rem_d;
    logic                 dzo_q, dzo_d;
    logic                 done_q, done_d;

    logic [WIDTH_D:0]     r_shift;
    logic [WIDTH_D:0]     r_sub;
    logic                 fits;
    logic                 last_iter;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dzo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dzo_q   <= dzo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        r_shift   = {r_q[WIDTH_D-1:0], q_q[WIDTH_N-1]};
        fits      = (r_shift >= {1'b0, d_q});
        r_sub     = r_shift - {1'b0, d_q};
        last_iter = (state_q == ITER) && (cnt_q == CW'(WIDTH_N - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)   state_d = ITER;
            ITER:    if (last_iter) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        q_d    = q_q;
        d_d    = d_q;
        r_d    = r_q;
        cnt_d  = cnt_q;
        dz_d   = dz_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dzo_d  = dzo_q;
        done_d = 1'b0;
        if (state_q == IDLE && start_i) begin
            q_d   = num_i;
            d_d   = den_i;
            r_d   = '0;
            cnt_d = '0;
            dz_d  = (den_i == '0);
        end else if (state_q == ITER) begin
            q_d   = {q_q[WIDTH_N-2:0], fits};
            r_d   = fits ? r_sub : r_shift;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
                // Divide-by-zero keeps the fixed latency but reports a saturated quotient.
                quot_d = dz_q ? {WIDTH_N{1'b1}} : q_d;
                rem_d  = dz_q ? '0 : r_d[WIDTH_D-1:0];
                dzo_d  = dz_q;
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        done_o  = done_q;
        quot_o  = quot_q;
        rem_o   = rem_q;
        dz_o    = dzo_q;
    end

endmodule

// File: tb/tb_div.sv
module tb_div;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [9:0] num_i = '0;
    logic [7:0] den_i = '0;
    logic       ready_o, done_o, dz_o;
    logic [9:0] quot_o;
    logic [7:0] rem_o;

    int checks = 0;
    int failures = 0;

    logic [9:0] exp_q = '0;
    logic [7:0] exp_r = '0;
    logic       exp_dz = 1'b0;
    logic [9:0] nq;
    logic [7:0] nr;
    logic       ndz;

    div #(.WIDTH_N(10), .WIDTH_D(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .num_i(num_i), .den_i(den_i),
        .ready_o(ready_o), .done_o(done_o), .quot_o(quot_o), .rem_o(rem_o), .dz_o(dz_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [9:0] n, input logic [7:0] d);
        if (d == 0) begin
            nq = 10'h3FF; nr = 8'd0; ndz = 1'b1;
        end else begin
            nq = 10'(int'(n) / int'(d));
            nr = 8'(int'(n) % int'(d));
            ndz = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Called while ready_o=1; leaves the bench in the done_o cycle of this operation.
    task automatic run_op(input logic [9:0] n, input logic [7:0] d,
                          input int inj_at, input logic [9:0] in_n, input logic [7:0] in_d);
        int lat;
        chk("ready_before_start", ready_o, 1);
        model(n, d);
        start_i = 1'b1; num_i = n; den_i = d;
        step();
        lat = 0;
        while (!done_o && lat < 30) begin
            chk("busy_ready_low", ready_o, 0);
            chk("hold_quot", quot_o, exp_q);
            chk("hold_rem", rem_o, exp_r);
            chk("hold_dz", dz_o, exp_dz);
            start_i = (lat == inj_at);
            num_i = (lat == inj_at) ? in_n : 10'($urandom);
            den_i = (lat == inj_at) ? in_d : 8'($urandom);
            step();
            lat++;
        end
        start_i = 1'b0;
        chk("latency", lat, 10);
        chk("done_pulse", done_o, 1);
        chk("ready_at_done", ready_o, 1);
        chk("quot", quot_o, nq);
        chk("rem", rem_o, nr);
        chk("dz", dz_o, ndz);
        exp_q = nq; exp_r = nr; exp_dz = ndz;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_no_done", done_o, 0);
            chk("idle_ready", ready_o, 1);
            chk("idle_quot", quot_o, exp_q);
        end
    endtask

    initial begin
        #12;
        chk("rst_ready", ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_quot", quot_o, 0);
        chk("rst_rem", rem_o, 0);
        chk("rst_dz", dz_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        run_op(10'd1000, 8'd7, -1, '0, '0);
        idle_cycles(2);
        run_op(10'd1023, 8'd255, -1, '0, '0);
        idle_cycles(1);
        run_op(10'd1023, 8'd1, -1, '0, '0);
        idle_cycles(1);
        run_op(10'd0, 8'd13, -1, '0, '0);
        idle_cycles(1);
        run_op(10'd5, 8'd0, -1, '0, '0);
        idle_cycles(1);
        run_op(10'd9, 8'd4, -1, '0, '0);
        idle_cycles(1);

        // Start while busy is dropped: only one completion follows.
        run_op(10'd100, 8'd3, 3, 10'd50, 8'd5);
        idle_cycles(12);

        // Back-to-back start in the done cycle.
        run_op(10'd100, 8'd3, -1, '0, '0);
        run_op(10'd200, 8'd9, -1, '0, '0);
        idle_cycles(1);

        // Reset mid-operation.
        start_i = 1'b1; num_i = 10'd1000; den_i = 8'd7;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_ni = 1'b0;
        #1;
        chk("midrst_ready", ready_o, 1);
        chk("midrst_done", done_o, 0);
        chk("midrst_quot", quot_o, 0);
        chk("midrst_rem", rem_o, 0);
        chk("midrst_dz", dz_o, 0);
        exp_q = '0; exp_r = '0; exp_dz = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle_cycles(15);
        run_op(10'd64, 8'd8, -1, '0, '0);
        idle_cycles(1);

        for (int k = 0; k < 25; k++) begin
            logic [9:0] rn;
            logic [7:0] rd;
            int inj;
            rn = 10'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            run_op(rn, rd, inj, 10'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
